flag_pipe_register: RTL and testbench
=====================================

Name: flag_pipe_register

Overview:
Parametrised condition-flag register for the pipelined CPU. Flag writes from EX travel through DEPTH in-flight slots and update the architectural flags only at commit. The block supports per-flag write masks, stall, and flush of speculative writes. It also provides a forwarded flag view so conditional branches see the youngest pending value without waiting for commit.

Parameters:
FLAG_W, 4, number of flag bits (N,Z,C,V in the default configuration)
DEPTH, 2, in-flight slots between write and commit; legal range 1..4
RESET_VAL, 4'b0000, architectural flag value after reset (width FLAG_W)
BYPASS_IN, 1, 1 = fwd_flags includes the same-cycle incoming write combinationally

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
set_en  input  1  a flag-setting instruction writes this cycle
set_mask  input  FLAG_W  per-flag write enable, qualified by set_en
set_vals  input  FLAG_W  new flag values
stall  input  1  hold all slots; no shift, no commit, incoming write ignored
flush  input  1  kill speculative in-flight writes
arch_flags  output  FLAG_W  committed flags, registered
fwd_flags  output  FLAG_W  youngest-value view for the branch condition check
pending  output  1  any slot valid with a nonzero mask
commit_valid  output  1  a slot with a nonzero mask commits at this edge (combinational, from slot DEPTH-1)

Behaviour:
- Reset (asynchronous, active-high): all slots valid=0, mask=0; arch_flags=RESET_VAL; pending=0; commit_valid=0.
- Slot k holds valid, mask[FLAG_W] and vals[FLAG_W]. Slot 0 is the youngest and slot DEPTH-1 is the oldest.
- Normal edge (stall=0, flush=0):
  - slot0 <= {set_en & |set_mask, set_mask, set_vals}.
  - slot[k] <= slot[k-1].
  - If slot[DEPTH-1] is valid: arch_flags[i] <= mask[i] ? vals[i] : arch_flags[i], per bit.
- Latency: a write accepted at edge t is visible on arch_flags after edge t+DEPTH.
- Stall edge (stall=1, flush=0): every slot holds, arch_flags holds, set_en is ignored. commit_valid is forced to 0 while stall=1.
- Flush edge (flush overrides stall):
  - Slots 0..DEPTH-2 and the incoming write are invalidated.
  - Slot DEPTH-1 still commits to arch_flags; it is non-speculative.
  - All slots are valid=0 after the edge.
  - With DEPTH=1, only the incoming write is killed.
- Masked-off bits never change arch_flags. A write with mask=0 is treated as invalid.
- fwd_flags, per bit i, in priority order:
  - set_vals[i] if BYPASS_IN, set_en and set_mask[i];
  - else vals[i] of the lowest-index valid slot with mask[i];
  - else arch_flags[i].
  - Different bits may resolve from different sources.
- fwd_flags ignores flush and stall in the same cycle; consumers qualify it themselves.
- pending is combinational from the slot state.
- Reset asserted mid-operation clears in-flight writes immediately without committing them.

Decomposition:
- Package flag_pkg:
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - a packed struct flag_slot_t {valid, mask, vals} parametrised by FLAG_W through the package constant FLAG_W_DEFAULT=4;
  - the legal DEPTH bound.
- Sub-module flag_slot: one slot register with async reset, load, hold and kill inputs. It is instantiated DEPTH times in a generate loop.
- Forwarding priority select and commit merge stay in the top level.

Test Plan:
- Reset, then idle -> arch_flags=0000, fwd_flags=0000, pending=0.
- Reset checked mid-operation: write 1010, assert reset one cycle later -> arch_flags=0000, pending=0 immediately, no commit afterwards.
- DEPTH=2, arch=0000; set_en=1, mask=1111, vals=1010 at edge 0:
  - fwd_flags=1010 in the same cycle;
  - pending=1 for 2 cycles;
  - arch_flags=1010 after edge 2.
- Partial masks: arch=1111; write mask=0100 vals=0000, next cycle write mask=0001 vals=0000 -> fwd_flags=1010 after the second edge; arch_flags=1011 then 1010 on consecutive commit edges.
- Youngest-wins forwarding: two back-to-back writes mask=1000, vals=1xxx then 0xxx -> fwd_flags[3]=0 while both are in flight.
- Stall: a write is in slot0, stall=1 for 3 cycles -> arch unchanged, pending stays 1, commit_valid=0, set_en during stall is dropped; commit happens DEPTH unstalled edges later.
- Flush with writes A in slot1 and B in slot0 (DEPTH=2), flush=1 plus an incoming write C -> A commits to arch_flags; B and C are lost; pending=0 after the edge.

Source files
------------

// File: rtl/flag_pkg.sv
// rtl/flag_pkg.sv - flag bit indices, in-flight slot record and legal depth bounds
package flag_pkg;

  localparam int FLAG_W_DEFAULT = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 4;

  typedef struct packed {
    logic                      valid;
    logic [FLAG_W_DEFAULT-1:0] mask;
    logic [FLAG_W_DEFAULT-1:0] vals;
  } flag_slot_t;

endpackage

// File: rtl/flag_pipe_register_if.sv
// rtl/flag_pipe_register_if.sv - flag write, pipeline control and flag view signals
interface flag_pipe_register_if #(
  parameter int FLAG_W = flag_pkg::FLAG_W_DEFAULT
) ();
  import flag_pkg::*;

  logic              set_en;
  logic [FLAG_W-1:0] set_mask;
  logic [FLAG_W-1:0] set_vals;
  logic              stall;
  logic              flush;
  logic [FLAG_W-1:0] arch_flags;
  logic [FLAG_W-1:0] fwd_flags;
  logic              pending;
  logic              commit_valid;

  modport master (
    output set_en, set_mask, set_vals, stall, flush,
    input  arch_flags, fwd_flags, pending, commit_valid
  );

  modport slave (
    input  set_en, set_mask, set_vals, stall, flush,
    output arch_flags, fwd_flags, pending, commit_valid
  );

endinterface

// File: rtl/flag_slot.sv
// rtl/flag_slot.sv - one in-flight flag write slot
// kill wins over load so a flush always leaves the slot empty.
module flag_slot
  import flag_pkg::*;
#(
  parameter int FLAG_W = FLAG_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              kill,
  input  logic              load_valid,
  input  logic [FLAG_W-1:0] load_mask,
  input  logic [FLAG_W-1:0] load_vals,
  output logic              valid,
  output logic [FLAG_W-1:0] mask,
  output logic [FLAG_W-1:0] vals
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      mask  <= '0;
      vals  <= '0;
    end else if (kill) begin
      valid <= 1'b0;
      mask  <= '0;
    end else if (load) begin
      valid <= load_valid;
      mask  <= load_mask;
      vals  <= load_vals;
    end
  end

endmodule

// File: rtl/flag_pipe_register.sv
// rtl/flag_pipe_register.sv - condition-flag register with delayed commit and forwarding
// Writes ride DEPTH slots before merging into arch_flags; fwd_flags shows the youngest value.
module flag_pipe_register
  import flag_pkg::*;
#(
  parameter int              FLAG_W    = FLAG_W_DEFAULT,
  parameter int              DEPTH     = 2,
  parameter logic [FLAG_W-1:0] RESET_VAL = '0,
  parameter bit              BYPASS_IN = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  flag_pipe_register_if.slave bus
);

  logic              in_valid;
  logic              shift_en;
  logic              commit_edge;
  logic              commit_fire;
  logic              pending_any;
  logic [FLAG_W-1:0] arch_q;
  logic [FLAG_W-1:0] fwd;

  logic              slot_valid [DEPTH];
  logic [FLAG_W-1:0] slot_mask  [DEPTH];
  logic [FLAG_W-1:0] slot_vals  [DEPTH];

  assign in_valid    = bus.set_en & (|bus.set_mask);
  assign shift_en    = ~bus.stall & ~bus.flush;
  // The oldest slot is non-speculative, so it still commits on a flush edge.
  assign commit_edge = ~bus.stall | bus.flush;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic              ld_valid;
    logic [FLAG_W-1:0] ld_mask;
    logic [FLAG_W-1:0] ld_vals;

    if (k == 0) begin : g_head
      assign ld_valid = in_valid;
      assign ld_mask  = bus.set_mask;
      assign ld_vals  = bus.set_vals;
    end else begin : g_body
      assign ld_valid = slot_valid[k-1];
      assign ld_mask  = slot_mask[k-1];
      assign ld_vals  = slot_vals[k-1];
    end

    flag_slot #(
      .FLAG_W(FLAG_W)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (shift_en),
      .kill      (bus.flush),
      .load_valid(ld_valid),
      .load_mask (ld_mask),
      .load_vals (ld_vals),
      .valid     (slot_valid[k]),
      .mask      (slot_mask[k]),
      .vals      (slot_vals[k])
    );
  end

  assign commit_fire = slot_valid[DEPTH-1] & (|slot_mask[DEPTH-1]) & commit_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arch_q <= RESET_VAL;
    end else if (commit_fire) begin
      arch_q <= (arch_q & ~slot_mask[DEPTH-1]) | (slot_vals[DEPTH-1] & slot_mask[DEPTH-1]);
    end
  end

  always_comb begin
    pending_any = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      pending_any = pending_any | (slot_valid[k] & (|slot_mask[k]));
    end
  end

  // Walk oldest to youngest so younger slots overwrite older ones bit by bit.
  always_comb begin
    fwd = arch_q;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (slot_valid[k]) begin
        fwd = (fwd & ~slot_mask[k]) | (slot_vals[k] & slot_mask[k]);
      end
    end
    if (BYPASS_IN && bus.set_en) begin
      fwd = (fwd & ~bus.set_mask) | (bus.set_vals & bus.set_mask);
    end
  end

  assign bus.arch_flags   = arch_q;
  assign bus.fwd_flags    = fwd;
  assign bus.pending      = pending_any;
  assign bus.commit_valid = commit_fire;

endmodule

// File: tb/tb_flag_pipe_register.sv
// tb/tb_flag_pipe_register.sv - directed and randomized checks against an in-bench flag model
module tb_flag_pipe_register;
  import flag_pkg::*;

  localparam int              FLAG_W    = FLAG_W_DEFAULT;
  localparam int              DEPTH     = 2;
  localparam logic [FLAG_W-1:0] RESET_VAL = 4'b0000;
  localparam bit              BYPASS_IN = 1'b1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  flag_pipe_register_if #(.FLAG_W(FLAG_W)) bus ();

  flag_pipe_register #(
    .FLAG_W   (FLAG_W),
    .DEPTH    (DEPTH),
    .RESET_VAL(RESET_VAL),
    .BYPASS_IN(BYPASS_IN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit check_on = 1'b0;

  // In-flight writes, youngest at the front; invalid writes carry no mask.
  flag_slot_t        m_q[$];
  logic [FLAG_W-1:0] m_arch;

  task automatic cmp(input string name, input logic [FLAG_W-1:0] act, input logic [FLAG_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_arch = RESET_VAL;
    m_q.delete();
    for (int k = 0; k < DEPTH; k++) m_q.push_back('0);
  endtask

  function automatic logic [FLAG_W-1:0] exp_fwd();
    logic [FLAG_W-1:0] f;
    bit done;
    for (int i = 0; i < FLAG_W; i++) begin
      done = 1'b0;
      f[i] = m_arch[i];
      if (BYPASS_IN && bus.set_en && bus.set_mask[i]) begin
        f[i] = bus.set_vals[i];
        done = 1'b1;
      end
      for (int k = 0; k < DEPTH && !done; k++) begin
        if (m_q[k].valid && m_q[k].mask[i]) begin
          f[i] = m_q[k].vals[i];
          done = 1'b1;
        end
      end
    end
    return f;
  endfunction

  function automatic logic exp_pending();
    foreach (m_q[k]) if (m_q[k].valid) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_commit();
    return m_q[DEPTH-1].valid && (!bus.stall || bus.flush);
  endfunction

  task automatic model_edge();
    flag_slot_t old;
    flag_slot_t inc;
    if (!bus.flush && bus.stall) return;
    old = m_q[DEPTH-1];
    if (old.valid) begin
      for (int i = 0; i < FLAG_W; i++) if (old.mask[i]) m_arch[i] = old.vals[i];
    end
    if (bus.flush) begin
      foreach (m_q[k]) m_q[k] = '0;
    end else begin
      inc = '0;
      if (bus.set_en && bus.set_mask != 0) begin
        inc.valid = 1'b1;
        inc.mask  = bus.set_mask;
        inc.vals  = bus.set_vals;
      end
      void'(m_q.pop_back());
      m_q.push_front(inc);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_edge();
  end

  always @(negedge clk) begin
    if (check_on) begin
      #2;
      cmp("arch_flags", bus.arch_flags, m_arch);
      cmp("fwd_flags", bus.fwd_flags, exp_fwd());
      cmp("pending", bus.pending, exp_pending());
      cmp("commit_valid", bus.commit_valid, exp_commit());
    end
  end

  task automatic drive(input logic en, input logic [3:0] mask, input logic [3:0] vals,
                       input logic st = 1'b0, input logic fl = 1'b0);
    @(negedge clk);
    bus.set_en   = en;
    bus.set_mask = mask;
    bus.set_vals = vals;
    bus.stall    = st;
    bus.flush    = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'b0000, 4'b0000);
  endtask

  initial begin
    bus.set_en   = 1'b0;
    bus.set_mask = '0;
    bus.set_vals = '0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    check_on = 1'b1;

    idle();
    cmp("rst_arch", bus.arch_flags, 4'b0000);
    cmp("rst_fwd", bus.fwd_flags, 4'b0000);
    cmp("rst_pending", bus.pending, 1'b0);
    cmp("rst_commit", bus.commit_valid, 1'b0);

    drive(1'b1, 4'b1111, 4'b1010);
    cmp("basic_bypass", bus.fwd_flags, 4'b1010);
    cmp("basic_pend0", bus.pending, 1'b0);
    idle();
    cmp("basic_pend1", bus.pending, 1'b1);
    cmp("basic_fwd1", bus.fwd_flags, 4'b1010);
    cmp("basic_arch1", bus.arch_flags, 4'b0000);
    idle();
    cmp("basic_pend2", bus.pending, 1'b1);
    cmp("basic_cv2", bus.commit_valid, 1'b1);
    cmp("basic_arch2", bus.arch_flags, 4'b0000);
    idle();
    cmp("basic_arch3", bus.arch_flags, 4'b1010);
    cmp("basic_pend3", bus.pending, 1'b0);

    drive(1'b1, 4'b1111, 4'b1111);
    idle();
    idle();
    drive(1'b1, 4'b0100, 4'b0000);
    cmp("part_arch0", bus.arch_flags, 4'b1111);
    drive(1'b1, 4'b0001, 4'b0000);
    idle();
    cmp("part_fwd", bus.fwd_flags, 4'b1010);
    cmp("part_arch1", bus.arch_flags, 4'b1111);
    idle();
    cmp("part_arch2", bus.arch_flags, 4'b1011);
    idle();
    cmp("part_arch3", bus.arch_flags, 4'b1010);

    drive(1'b1, 4'b1000, 4'b1000);
    drive(1'b1, 4'b1000, 4'b0000);
    cmp("young_bypass", bus.fwd_flags, 4'b0010);
    idle();
    cmp("young_both", bus.fwd_flags, 4'b0010);
    idle();
    cmp("young_one", bus.fwd_flags, 4'b0010);
    idle();
    cmp("young_arch", bus.arch_flags, 4'b0010);

    drive(1'b1, 4'b0001, 4'b0001);
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0);
      cmp("stall_pend", bus.pending, 1'b1);
      cmp("stall_cv", bus.commit_valid, 1'b0);
      cmp("stall_arch", bus.arch_flags, 4'b0010);
    end
    idle();
    cmp("stall_u1_cv", bus.commit_valid, 1'b0);
    cmp("stall_u1_pend", bus.pending, 1'b1);
    idle();
    cmp("stall_u2_cv", bus.commit_valid, 1'b1);
    idle();
    cmp("stall_arch_end", bus.arch_flags, 4'b0011);
    cmp("stall_pend_end", bus.pending, 1'b0);

    drive(1'b1, 4'b1100, 4'b1100);
    drive(1'b1, 4'b0011, 4'b0000);
    drive(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1);
    cmp("flush_cv", bus.commit_valid, 1'b1);
    idle();
    cmp("flush_arch", bus.arch_flags, 4'b1111);
    cmp("flush_pend", bus.pending, 1'b0);
    idle();
    cmp("flush_arch2", bus.arch_flags, 4'b1111);

    drive(1'b1, 4'b1111, 4'b0101);
    idle();
    cmp("midrst_pend_pre", bus.pending, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    cmp("midrst_arch", bus.arch_flags, 4'b0000);
    cmp("midrst_pend", bus.pending, 1'b0);
    cmp("midrst_fwd", bus.fwd_flags, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) idle();
    cmp("midrst_arch_after", bus.arch_flags, 4'b0000);
    cmp("midrst_pend_after", bus.pending, 1'b0);

    repeat (400) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0));
    end
    repeat (4) idle();

    check_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
